pong_match_ctrl: RTL

Parametrised match controller for the Pong display pipeline. It detects per-player goal misses from the shared scan signals: `active_obj`, per-player paddle activity and per-player goal-line flags. It keeps one score per player, sequences serve pauses and game-over, and drives the reset into the ball and paddle blocks. It sits beside `hdmi_transmit` on `pixel_clk`, and all of its decisions are made on frame boundaries (`fsync`).

---
 rtl/pong_match_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: frame-synchronous match controller for the Pong pipeline.
// Detects unguarded goal-line crossings per player, keeps saturating scores,
// sequences serve pauses and game-over, and holds ball/paddles in reset.
// Optional feature macro: PONG_AUTO_RESTART_EN (timed restart from game-over).
module pong_match_ctrl #(
   parameter int NUM_PLAYERS    = 2,
   parameter int SCORE_W        = 4,
   parameter int WIN_SCORE      = 7,
   parameter int SERVE_PAUSE    = 64,
   parameter int GAMEOVER_PAUSE = 128,
   parameter int PAUSE_W        = 8,
   parameter int WIN_W          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           pixel_clk,
   input  logic                           rst_n,
   input  logic                           fsync,
   input  logic                           active_obj,
   input  logic [NUM_PLAYERS-1:0]         active_paddle,
   input  logic [NUM_PLAYERS-1:0]         goal_line,
   input  logic                           start,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score,
   output logic [NUM_PLAYERS-1:0]         point,
   output logic                           serve_rst,
   output logic                           game_over,
   output logic [WIN_W-1:0]               winner
);

   typedef enum logic [1:0] {
      PLAY,
      SERVE,
      GAME_OVER
   } state_t;

   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [PAUSE_W-1:0] SERVE_LAST = PAUSE_W'(SERVE_PAUSE);
   localparam logic [PAUSE_W-1:0] OVER_LAST  = PAUSE_W'(GAMEOVER_PAUSE);

   state_t                                 state_q, state_d;
   logic [NUM_PLAYERS-1:0]                 seen_q, seen_d;
   logic [NUM_PLAYERS-1:0]                 hit_q, hit_d;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_q, score_d;
   logic [NUM_PLAYERS-1:0]                 point_q, point_d;
   logic                                   serve_rst_q, serve_rst_d;
   logic                                   game_over_q, game_over_d;
   logic [WIN_W-1:0]                       winner_q, winner_d;
   logic [PAUSE_W-1:0]                     cnt_q, cnt_d;

   logic [NUM_PLAYERS-1:0]                 miss;
   logic [NUM_PLAYERS-1:0]                 award;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_upd;
   logic                                   win_any;
   logic [WIN_W-1:0]                       win_idx;
   logic [PAUSE_W-1:0]                     cnt_inc;
   logic [PAUSE_W-1:0]                     pause_limit;
   logic                                   pause_done;

   // Per-frame ball/goal trackers; only accumulate during play, reset each frame
   always_comb begin
      seen_d = '0;
      hit_d  = '0;
      if (state_q == PLAY && !fsync) begin
         seen_d = seen_q | ({NUM_PLAYERS{active_obj}} & goal_line);
         hit_d  = hit_q  | ({NUM_PLAYERS{active_obj}} & goal_line & active_paddle);
      end
   end

   // Miss detection, ring award (miss by i scores for i+1) and winner search
   always_comb begin
      miss    = seen_q & ~hit_q;
      award   = {miss[NUM_PLAYERS-2:0], miss[NUM_PLAYERS-1]};
      win_any = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (award[i] && (score_q[i] < WIN_VAL)) begin
            score_upd[i] = score_q[i] + SCORE_W'(1);
         end else begin
            score_upd[i] = score_q[i];
         end
      end
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (score_upd[i] == WIN_VAL) begin
            win_any = 1'b1;
            win_idx = WIN_W'(i);
         end
      end
   end

   // Frame counter arithmetic shared by the serve and game-over pauses
   always_comb begin
      cnt_inc     = cnt_q + PAUSE_W'(1);
      pause_limit = (state_q == GAME_OVER) ? OVER_LAST : SERVE_LAST;
      pause_done  = (cnt_inc == pause_limit);
   end

   // Match state machine: next state, scores, point pulse, winner and counter
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      point_d  = '0;
      winner_d = winner_q;
      cnt_d    = cnt_q;
      case (state_q)
         PLAY: begin
            if (fsync) begin
               score_d = score_upd;
               point_d = award;
               if (win_any) begin
                  state_d  = GAME_OVER;
                  winner_d = win_idx;
                  cnt_d    = '0;
               end else if (|miss) begin
                  state_d = SERVE;
                  cnt_d   = '0;
               end
            end
         end
         SERVE: begin
            if (fsync) begin
               if (pause_done) begin
                  state_d = PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         GAME_OVER: begin
            if (start) begin
               state_d  = PLAY;
               score_d  = '0;
               winner_d = '0;
               cnt_d    = '0;
            end
`ifdef PONG_AUTO_RESTART_EN
            else if (fsync) begin
               if (pause_done) begin
                  state_d  = PLAY;
                  score_d  = '0;
                  winner_d = '0;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
`else
            else begin
               cnt_d = '0;
            end
`endif
         end
         default: begin
            state_d = PLAY;
         end
      endcase
      serve_rst_d = (state_d != PLAY);
      game_over_d = (state_d == GAME_OVER);
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PLAY;
         seen_q      <= '0;
         hit_q       <= '0;
         score_q     <= '0;
         point_q     <= '0;
         serve_rst_q <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         seen_q      <= seen_d;
         hit_q       <= hit_d;
         score_q     <= score_d;
         point_q     <= point_d;
         serve_rst_q <= serve_rst_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         cnt_q       <= cnt_d;
      end
   end

   assign score     = score_q;
   assign point     = point_q;
   assign serve_rst = serve_rst_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule
